// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit:
// FSM states, instruction classes, opcode patterns, ALUOp and fault codes.
package ctrl_pkg;

    localparam int OPCODE_W = 11;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        IC_ILLEGAL = 4'd0,
        IC_LDUR    = 4'd1,
        IC_STUR    = 4'd2,
        IC_CBZ     = 4'd3,
        IC_CBNZ    = 4'd4,
        IC_B       = 4'd5,
        IC_ADDI    = 4'd6,
        IC_SUBI    = 4'd7,
        IC_RTYPE   = 4'd8
    } iclass_t;

    // Don't-care bits are written as '?' so these can be used directly as casez items.
    localparam logic [OPCODE_W-1:0] PAT_LDUR  = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] PAT_STUR  = 11'b11111000000;
    localparam logic [OPCODE_W-1:0] PAT_CBZ   = 11'b10110100???;
    localparam logic [OPCODE_W-1:0] PAT_CBNZ  = 11'b10110101???;
    localparam logic [OPCODE_W-1:0] PAT_B     = 11'b000101?????;
    localparam logic [OPCODE_W-1:0] PAT_ADDI  = 11'b1001000100?;
    localparam logic [OPCODE_W-1:0] PAT_SUBI  = 11'b1101000100?;
    localparam logic [OPCODE_W-1:0] PAT_RTYPE = 11'b???0101?000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_IMEM_TO = 2'b10;
    localparam logic [1:0] FC_DMEM_TO = 2'b11;

    function automatic logic is_mem_class(input iclass_t ic);
        return (ic == IC_LDUR) || (ic == IC_STUR);
    endfunction

endpackage

// File: rtl/op_classifier.sv
// Combinational opcode classifier: maps an 11-bit LEGv8 opcode to its
// instruction class, first matching pattern wins.
module op_classifier
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] op,
    output iclass_t             iclass
);

    always_comb begin
        iclass = IC_ILLEGAL;
        casez (op)
            PAT_LDUR:  iclass = IC_LDUR;
            PAT_STUR:  iclass = IC_STUR;
            PAT_CBZ:   iclass = IC_CBZ;
            PAT_CBNZ:  iclass = IC_CBNZ;
            PAT_B:     iclass = IC_B;
            PAT_ADDI:  iclass = IC_ADDI;
            PAT_SUBI:  iclass = IC_SUBI;
            PAT_RTYPE: iclass = IC_RTYPE;
            default:   iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM with handshaked instruction/data memories,
// per-access timeout, sticky fault reporting and a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 11,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWrite,
    output logic             PCInc,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             BranchNZ,
    output logic             UncondBranch,
    output logic [1:0]       ALUOp,
    output logic [2:0]       state,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            cur_state;
    logic [OP_W-1:0]   ir_op;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        fault_code_q;
    logic [CNT_W-1:0]  retired_q;
    iclass_t           iclass;

    op_classifier u_classifier (
        .op     (ir_op),
        .iclass (iclass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state    <= FETCH;
            ir_op        <= '0;
            wait_cnt     <= '0;
            fault_code_q <= FC_NONE;
            retired_q    <= '0;
        end else begin
            case (cur_state)
                FETCH: begin
                    // A ready arriving on the limit cycle still completes the fetch.
                    if (imem_ready) begin
                        ir_op     <= op;
                        wait_cnt  <= '0;
                        cur_state <= DECODE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        wait_cnt     <= '0;
                        fault_code_q <= FC_IMEM_TO;
                        cur_state    <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    if (iclass == IC_ILLEGAL) begin
                        fault_code_q <= FC_ILLEGAL;
                        cur_state    <= FAULT;
                    end else if (iclass == IC_B) begin
                        retired_q <= retired_q + 1'b1;
                        cur_state <= FETCH;
                    end else begin
                        cur_state <= EXEC;
                    end
                end
                EXEC: begin
                    case (iclass)
                        IC_LDUR, IC_STUR: cur_state <= MEM;
                        IC_CBZ, IC_CBNZ: begin
                            retired_q <= retired_q + 1'b1;
                            cur_state <= FETCH;
                        end
                        IC_RTYPE, IC_ADDI, IC_SUBI: cur_state <= WB;
                        default: begin
                            fault_code_q <= FC_ILLEGAL;
                            cur_state    <= FAULT;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        if (iclass == IC_LDUR) begin
                            cur_state <= WB;
                        end else begin
                            retired_q <= retired_q + 1'b1;
                            cur_state <= FETCH;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        wait_cnt     <= '0;
                        fault_code_q <= FC_DMEM_TO;
                        cur_state    <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB: begin
                    retired_q <= retired_q + 1'b1;
                    cur_state <= FETCH;
                end
                FAULT:   cur_state <= FAULT;
                default: cur_state <= FETCH;
            endcase
        end
    end

    // Controls are held at zero while reset is asserted, even though the state is FETCH.
    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        IRWrite      = 1'b0;
        PCInc        = 1'b0;
        Reg2Loc      = 1'b0;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        BranchNZ     = 1'b0;
        UncondBranch = 1'b0;
        ALUOp        = ALU_ADD;
        if (reset) begin
            case (cur_state)
                FETCH: begin
                    imem_req = 1'b1;
                    IRWrite  = imem_ready;
                    PCInc    = imem_ready;
                end
                DECODE: UncondBranch = (iclass == IC_B);
                EXEC: begin
                    case (iclass)
                        IC_LDUR: begin
                            ALUSrc = 1'b1;
                            ALUOp  = ALU_ADD;
                        end
                        IC_STUR: begin
                            ALUSrc  = 1'b1;
                            Reg2Loc = 1'b1;
                            ALUOp   = ALU_ADD;
                        end
                        IC_CBZ, IC_CBNZ: begin
                            Reg2Loc  = 1'b1;
                            Branch   = 1'b1;
                            BranchNZ = (iclass == IC_CBNZ);
                            ALUOp    = ALU_PASSB;
                        end
                        IC_RTYPE: ALUOp = ALU_RTYPE;
                        IC_ADDI, IC_SUBI: begin
                            ALUSrc = 1'b1;
                            ALUOp  = ALU_IMM;
                        end
                        default: ALUOp = ALU_ADD;
                    endcase
                end
                MEM: begin
                    dmem_req = is_mem_class(iclass);
                    MemRead  = (iclass == IC_LDUR);
                    MemWrite = (iclass == IC_STUR);
                end
                WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (iclass == IC_LDUR);
                end
                default: ALUOp = ALU_ADD;
            endcase
        end
    end

    assign state      = cur_state;
    assign fault      = (cur_state == FAULT);
    assign fault_code = fault_code_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes its expected
// state/control/fault/retired snapshot, which a monitor pops and compares.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   op;
    logic          imem_ready, dmem_ready;
    logic          imem_req, dmem_req, IRWrite, PCInc, Reg2Loc, ALUSrc, MemtoReg;
    logic          RegWrite, MemRead, MemWrite, Branch, BranchNZ, UncondBranch;
    logic [1:0]    ALUOp;
    logic [2:0]    state;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] retired;
    logic [14:0]   ctl_obs;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OP_W(11), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCInc(PCInc),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .BranchNZ(BranchNZ),
        .UncondBranch(UncondBranch), .ALUOp(ALUOp), .state(state), .fault(fault),
        .fault_code(fault_code), .retired(retired)
    );

    assign ctl_obs = {imem_req, dmem_req, IRWrite, PCInc, Reg2Loc, ALUSrc, MemtoReg,
                      RegWrite, MemRead, MemWrite, Branch, BranchNZ, UncondBranch, ALUOp};

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_X = 3'd7;

    localparam logic [14:0] IREQ = 15'h4000, DREQ = 15'h2000, IRW = 15'h1000, PCI = 15'h0800;
    localparam logic [14:0] R2L = 15'h0400, ASRC = 15'h0200, M2R = 15'h0100, RW = 15'h0080;
    localparam logic [14:0] MR = 15'h0040, MW = 15'h0020, BR = 15'h0010, BNZ = 15'h0008;
    localparam logic [14:0] UB = 15'h0004, AO_PB = 15'h0001, AO_R = 15'h0002, AO_I = 15'h0003;
    localparam logic [14:0] FETCH_OK = IREQ | IRW | PCI;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001001;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101011;
    localparam logic [10:0] OP_CBZ  = 11'b10110100111;
    localparam logic [10:0] OP_B    = 11'b00010111111;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    typedef struct {
        string       tag;
        logic [24:0] exp;
    } item_t;

    item_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [CW-1:0] exp_retired;

    task automatic checkOutput(input string tag, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual state=%0d ctl=%h fault=%b code=%b retired=%0d, required state=%0d ctl=%h fault=%b code=%b retired=%0d",
                     tag, got[24:22], got[21:7], got[6], got[5:4], got[3:0],
                     exp[24:22], exp[21:7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst_v, input logic ir, input logic dr,
                                 input logic [10:0] op_v, input logic [2:0] est,
                                 input logic [14:0] ectl, input logic ef, input logic [1:0] ecode);
        item_t it;
        @(negedge clk);
        reset      = rst_v;
        imem_ready = ir;
        dmem_ready = dr;
        op         = op_v;
        it.tag = tag;
        it.exp = {est, ectl, ef, ecode, exp_retired};
        sb.push_back(it);
    endtask

    task automatic fetchOk(input string tag, input logic [10:0] o);
        applyStimulus(tag, 1'b1, 1'b1, 1'b0, o, S_F, FETCH_OK, 1'b0, 2'b00);
    endtask

    // Non-memory cycles drive stray readies and a junk opcode, both of which must be ignored.
    task automatic idle(input string tag, input logic [2:0] st, input logic [14:0] c);
        applyStimulus(tag, 1'b1, 1'b1, 1'b1, OP_BAD, st, c, 1'b0, 2'b00);
    endtask

    task automatic doReset(input string tag);
        exp_retired = '0;
        applyStimulus(tag, 1'b0, 1'b1, 1'b1, OP_BAD, S_F, 15'h0, 1'b0, 2'b00);
    endtask

    always @(negedge clk) begin
        item_t it;
        #2;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            checkOutput(it.tag, {state, ctl_obs, fault, fault_code, retired}, it.exp);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; op = '0;
        exp_retired = '0;
        doReset("reset_hold0");
        doReset("reset_hold1");

        fetchOk("add_fetch", OP_ADD);
        idle("add_decode", S_D, 15'h0);
        idle("add_exec", S_E, AO_R);
        idle("add_wb", S_W, RW);
        exp_retired++;

        fetchOk("addi_fetch", OP_ADDI);
        idle("addi_decode", S_D, 15'h0);
        idle("addi_exec", S_E, ASRC | AO_I);
        idle("addi_wb", S_W, RW);
        exp_retired++;

        fetchOk("subi_fetch", OP_SUBI);
        idle("subi_decode", S_D, 15'h0);
        idle("subi_exec", S_E, ASRC | AO_I);
        idle("subi_wb", S_W, RW);
        exp_retired++;

        fetchOk("ldur_fetch", OP_LDUR);
        idle("ldur_decode", S_D, 15'h0);
        idle("ldur_exec", S_E, ASRC);
        for (int i = 0; i < 3; i++)
            applyStimulus("ldur_mem_wait", 1'b1, 1'b1, 1'b0, OP_BAD, S_M, DREQ | MR, 1'b0, 2'b00);
        applyStimulus("ldur_mem_done", 1'b1, 1'b0, 1'b1, OP_BAD, S_M, DREQ | MR, 1'b0, 2'b00);
        idle("ldur_wb", S_W, RW | M2R);
        exp_retired++;

        fetchOk("stur_fetch", OP_STUR);
        idle("stur_decode", S_D, 15'h0);
        idle("stur_exec", S_E, R2L | ASRC);
        applyStimulus("stur_mem", 1'b1, 1'b0, 1'b1, OP_BAD, S_M, DREQ | MW, 1'b0, 2'b00);
        exp_retired++;

        fetchOk("cbnz_fetch", OP_CBNZ);
        idle("cbnz_decode", S_D, 15'h0);
        idle("cbnz_exec", S_E, R2L | BR | BNZ | AO_PB);
        exp_retired++;

        fetchOk("cbz_fetch", OP_CBZ);
        idle("cbz_decode", S_D, 15'h0);
        idle("cbz_exec", S_E, R2L | BR | AO_PB);
        exp_retired++;

        fetchOk("b_fetch", OP_B);
        idle("b_decode", S_D, UB);
        exp_retired++;

        for (int i = 0; i < 3; i++)
            applyStimulus("bwait_fetch", 1'b1, 1'b0, 1'b1, OP_BAD, S_F, IREQ, 1'b0, 2'b00);
        fetchOk("bwait_fetch_limit", OP_B);
        idle("bwait_decode", S_D, UB);
        exp_retired++;

        fetchOk("ill_fetch", OP_BAD);
        idle("ill_decode", S_D, 15'h0);
        for (int i = 0; i < 2; i++)
            applyStimulus("ill_fault", 1'b1, 1'b1, 1'b1, OP_ADD, S_X, 15'h0, 1'b1, 2'b01);

        doReset("reset_after_ill");
        for (int i = 0; i < 4; i++)
            applyStimulus("ito_fetch", 1'b1, 1'b0, 1'b0, OP_ADD, S_F, IREQ, 1'b0, 2'b00);
        for (int i = 0; i < 2; i++)
            applyStimulus("ito_fault", 1'b1, 1'b1, 1'b0, OP_ADD, S_X, 15'h0, 1'b1, 2'b10);

        doReset("reset_after_ito");
        fetchOk("dto_fetch", OP_LDUR);
        idle("dto_decode", S_D, 15'h0);
        idle("dto_exec", S_E, ASRC);
        for (int i = 0; i < 4; i++)
            applyStimulus("dto_mem", 1'b1, 1'b0, 1'b0, OP_BAD, S_M, DREQ | MR, 1'b0, 2'b00);
        applyStimulus("dto_fault", 1'b1, 1'b1, 1'b1, OP_BAD, S_X, 15'h0, 1'b1, 2'b11);

        doReset("reset_after_dto");
        fetchOk("pre_b_fetch", OP_B);
        idle("pre_b_decode", S_D, UB);
        exp_retired++;
        fetchOk("rst_stur_fetch", OP_STUR);
        idle("rst_stur_decode", S_D, 15'h0);
        idle("rst_stur_exec", S_E, R2L | ASRC);
        applyStimulus("rst_stur_mem", 1'b1, 1'b0, 1'b0, OP_BAD, S_M, DREQ | MW, 1'b0, 2'b00);
        doReset("rst_mid_mem");
        applyStimulus("post_rst_fetch", 1'b1, 1'b0, 1'b0, OP_BAD, S_F, IREQ, 1'b0, 2'b00);

        for (int i = 0; i < 16; i++) begin
            fetchOk("wrap_b_fetch", OP_B);
            idle("wrap_b_decode", S_D, UB);
            exp_retired++;
        end
        applyStimulus("wrap_fetch", 1'b1, 1'b0, 1'b0, OP_BAD, S_F, IREQ, 1'b0, 2'b00);

        @(negedge clk);
        #5;
        checkOutput("sb_drained", 25'(sb.size()), 25'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
